aes_mix_columns: RTL and testbench

//  - AES-128 MixColumns stage for the area-optimised pipelined encryption datapath.
//  - Multiplies each of the 4 state columns by the fixed GF(2^8) matrix [2 3 1 1; 1 2 3 1; 1 1 2 3; 3 1 1 2].
//  - Sits between ShiftRows and AddRoundKey; output is registered, one pipeline stage deep.

---
 rtl/aes_pkg.sv | 10 +
 rtl/aes_mix_single_column.sv | 19 +
 rtl/aes_mix_columns.sv | 27 ++
 tb/tb_aes_mix_columns.sv | 135 +++++++++++++
 4 files changed

// File: rtl/aes_pkg.sv
// aes_pkg: shared AES types, field polynomial and xtime helper
package aes_pkg;
  localparam logic [7:0] AES_POLY = 8'h1B;
  typedef logic [7:0] byte_t;
  typedef logic [31:0] word_t;
  typedef logic [127:0] state_t;
  function automatic byte_t xtime(input byte_t x);
    return {x[6:0], 1'b0} ^ (x[7] ? AES_POLY : 8'h00);
  endfunction
endpackage

// File: rtl/aes_mix_single_column.sv
// aes_mix_single_column: combinational MixColumns on one 32-bit column (col_in -> col_out, row 0 in top byte)
module aes_mix_single_column
  import aes_pkg::*;
(
  input  logic [31:0] col_in,
  output logic [31:0] col_out
);
  byte_t a0, a1, a2, a3;
  byte_t x0, x1, x2, x3;
  assign {a0, a1, a2, a3} = col_in;
  assign x0 = xtime(a0);
  assign x1 = xtime(a1);
  assign x2 = xtime(a2);
  assign x3 = xtime(a3);
  assign col_out = {x0 ^ x1 ^ a1 ^ a2 ^ a3,
                    a0 ^ x1 ^ x2 ^ a2 ^ a3,
                    a0 ^ a1 ^ x2 ^ x3 ^ a3,
                    x0 ^ a0 ^ a1 ^ a2 ^ x3};
endmodule

// File: rtl/aes_mix_columns.sv
// aes_mix_columns: registered AES MixColumns (clk, rst, in_valid, state_in -> out_valid, state_out)
module aes_mix_columns
  import aes_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  input  logic [127:0] state_in,
  output logic         out_valid,
  output logic [127:0] state_out
);
  state_t mixed;
  for (genvar c = 0; c < 4; c++) begin : g_col
    aes_mix_single_column u_col (
      .col_in (state_in[127-32*c -: 32]),
      .col_out(mixed[127-32*c -: 32])
    );
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state_out <= '0;
      out_valid <= 1'b0;
    end else begin
      state_out <= mixed;
      out_valid <= in_valid;
    end
endmodule

// File: tb/tb_aes_mix_columns.sv
// tb_aes_mix_columns: scoreboard bench for aes_mix_columns with directed and random blocks
module tb_aes_mix_columns;
  typedef struct packed {
    logic         v;
    logic [127:0] d;
  } exp_t;
  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         in_valid = 1'b0;
  logic [127:0] state_in = '0;
  logic         out_valid;
  logic [127:0] state_out;
  exp_t         sb[$];
  exp_t         mon_e;
  int           n_cmp = 0;
  int           n_err = 0;
  localparam logic [127:0] VA = 128'h876E46A6F24CE78C4D904AD897ECC395;
  localparam logic [127:0] RA = 128'h473794ED40D4E4A5A3703AA64C9F42BC;
  localparam logic [127:0] VB = 128'h632FAFA2EB93C7209F92ABCBA0C0302B;
  localparam logic [127:0] RB = 128'hBA75F47A84A48D32E88D060E1B407D5D;
  aes_mix_columns dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .state_in (state_in),
    .out_valid(out_valid),
    .state_out(state_out)
  );
  always #5 clk = ~clk;
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = '0;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p ^= x;
      x = x[7] ? ((x << 1) ^ 8'h1B) : (x << 1);
    end
    return p;
  endfunction
  function automatic logic [127:0] mc(input logic [127:0] s);
    logic [7:0] m [4];
    logic [7:0] acc;
    logic [127:0] r;
    m = '{8'd2, 8'd3, 8'd1, 8'd1};
    r = '0;
    for (int c = 0; c < 4; c++)
      for (int row = 0; row < 4; row++) begin
        acc = '0;
        for (int k = 0; k < 4; k++)
          acc ^= gmul(m[(k - row) & 3], s[127 - 8*(4*c + k) -: 8]);
        r[127 - 8*(4*c + row) -: 8] = acc;
      end
    return r;
  endfunction
  task automatic cmp(input string nm, input logic [127:0] act, input logic [127:0] req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, req);
    end
  endtask
  task automatic put(input logic v, input logic [127:0] d, input logic [127:0] e);
    exp_t x;
    in_valid = v;
    state_in = d;
    x.v = v;
    x.d = e;
    sb.push_back(x);
  endtask
  task automatic drive(input logic v, input logic [127:0] d, input logic [127:0] e);
    @(negedge clk);
    put(v, d, e);
  endtask
  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction
  task automatic rst_pulse();
    logic [127:0] d;
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    cmp("rst_async_valid", {127'd0, out_valid}, 128'd0);
    cmp("rst_async_data", state_out, 128'd0);
    sb.delete();
    @(negedge clk);
    cmp("rst_hold_valid", {127'd0, out_valid}, 128'd0);
    cmp("rst_hold_data", state_out, 128'd0);
    rst = 1'b0;
    d = rnd128();
    put(1'b1, d, mc(d));
  endtask
  always @(posedge clk) begin
    #1;
    if (!rst && sb.size() > 0) begin
      mon_e = sb.pop_front();
      cmp("out_valid", {127'd0, out_valid}, {127'd0, mon_e.v});
      cmp("state_out", state_out, mon_e.d);
    end
  end
  initial begin
    logic [127:0] d;
    logic         v;
    int           w;
    in_valid = 1'b1;
    state_in = rnd128();
    repeat (2) @(posedge clk);
    rst_pulse();
    drive(1'b1, 128'h0, 128'h0);
    drive(1'b1, VA, RA);
    drive(1'b1, VB, RB);
    drive(1'b0, 128'h0, 128'h0);
    drive(1'b1, VA, RA);
    drive(1'b1, VB, RB);
    drive(1'b0, 128'h0, 128'h0);
    for (int i = 0; i < 1000; i++) begin
      if (i == 500) rst_pulse();
      d = rnd128();
      v = ($urandom_range(0, 3) != 0);
      drive(v, d, mc(d));
    end
    w = 0;
    while (sb.size() > 0 && w < 10) begin
      @(negedge clk);
      w++;
    end
    if (sb.size() > 0) begin
      n_cmp++;
      n_err++;
      $display("FAIL drain: %0d outputs still pending, expected 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end
endmodule
